// File: rtl/panel_key_encoder_pkg.sv
// Shared encodings for the front-panel key encoder: event types and the
// physical button indices on the panel connector.
package panel_key_encoder_pkg;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_LONG    = 2'd1,
    EV_RELEASE = 2'd2
  } ev_type_e;

  typedef enum int {
    BTN_RESET = 0,
    BTN_RUN   = 1,
    BTN_WATER = 2,
    BTN_OPEN  = 3,
    BTN_CLICK = 4
  } btn_idx_e;

endpackage

// File: rtl/panel_key_encoder_debounce.sv
// One button: 2-flop synchronizer, stable-level debounce and long-hold timer.
// Event outputs are single-cycle pulses aligned with the level update.
module key_debounce
  import panel_key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int LONG_CYC     = 2000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press_p,
  output logic o_long_p,
  output logic o_release_p
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int LW = $clog2(LONG_CYC + 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic [DW-1:0] r_db_cnt;
  logic [LW-1:0] r_long_cnt;
  logic          w_accept;
  logic          w_long_hit;

  assign w_accept   = (r_sync1 != r_level) && (r_db_cnt == DW'(DEBOUNCE_CYC - 1));
  assign w_long_hit = r_level && (r_long_cnt == LW'(LONG_CYC - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync0    <= 1'b0;
      r_sync1    <= 1'b0;
      r_level    <= 1'b0;
      r_db_cnt   <= '0;
      r_long_cnt <= '0;
    end else begin
      r_sync0 <= i_raw;
      r_sync1 <= r_sync0;
      if (r_sync1 == r_level) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_level  <= r_sync1;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
      // Parks one past the fire point so a single hold yields a single LONG.
      if (!r_level) begin
        r_long_cnt <= '0;
      end else if (r_long_cnt != LW'(LONG_CYC)) begin
        r_long_cnt <= r_long_cnt + LW'(1);
      end
    end
  end

  assign o_level     = r_level;
  assign o_press_p   = w_accept && r_sync1;
  assign o_release_p = w_accept && !r_sync1;
  assign o_long_p    = w_long_hit;

endmodule

// File: rtl/panel_key_encoder.sv
// Front-panel key encoder: per-button debounce, pending-event arbiter and an
// event FIFO presented to the state controller as a valid/ready stream.
module panel_key_encoder
  import panel_key_encoder_pkg::*;
#(
  parameter int NUM_BTN      = 5,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int LONG_CYC     = 2000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [1:0]                 ev_type,
  output logic [$clog2(NUM_BTN)-1:0] ev_id,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic                       overflow,
  input  logic                       ovf_clr
);
  localparam int IDW = $clog2(NUM_BTN);
  localparam int PW  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    ev_type_e       ev_type;
    logic [IDW-1:0] id;
  } ev_t;

  logic [NUM_BTN-1:0] w_press_p, w_long_p, w_rel_p;
  logic [NUM_BTN-1:0] r_pend_press, r_pend_long, r_pend_rel;
  logic [NUM_BTN-1:0] w_clr_press, w_clr_long, w_clr_rel;
  logic               w_sel_valid;
  ev_t                w_sel_ev;
  ev_t                r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [PW:0]        r_count;
  logic               r_overflow;
  logic               w_full, w_pop, w_push, w_drop;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_db (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_raw      (btn_raw[g]),
      .o_level    (btn_level[g]),
      .o_press_p  (w_press_p[g]),
      .o_long_p   (w_long_p[g]),
      .o_release_p(w_rel_p[g])
    );
  end

  // Descending scan so the lowest pending button is the last (winning) write.
  // RELEASE is reached only when PRESS and LONG of that button are clear.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_ev    = '0;
    w_clr_press = '0;
    w_clr_long  = '0;
    w_clr_rel   = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pend_press[i] || r_pend_long[i] || r_pend_rel[i]) begin
        w_sel_valid = 1'b1;
        w_sel_ev.id = IDW'(i);
        w_clr_press = '0;
        w_clr_long  = '0;
        w_clr_rel   = '0;
        if (r_pend_press[i]) begin
          w_sel_ev.ev_type = EV_PRESS;
          w_clr_press[i]   = 1'b1;
        end else if (r_pend_long[i]) begin
          w_sel_ev.ev_type = EV_LONG;
          w_clr_long[i]    = 1'b1;
        end else begin
          w_sel_ev.ev_type = EV_RELEASE;
          w_clr_rel[i]     = 1'b1;
        end
      end
    end
  end

  // Stream: an event transfers on any cycle with ev_valid && ev_ready. ev_valid
  // and the head payload come only from registers, never from ev_ready, and
  // ev_ready while the queue is empty has no effect.
  assign w_full   = (r_count == (PW + 1)'(FIFO_DEPTH));
  assign ev_valid = (r_count != '0);
  assign w_pop    = ev_valid && ev_ready;
  assign w_push   = w_sel_valid && (!w_full || w_pop);
  assign w_drop   = w_sel_valid && w_full && !w_pop;
  assign ev_type  = r_mem[r_rd_ptr].ev_type;
  assign ev_id    = r_mem[r_rd_ptr].id;
  assign overflow = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_press <= '0;
      r_pend_long  <= '0;
      r_pend_rel   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // A selected event leaves its pending bit whether queued or dropped;
      // a new edge on a still-pending bit simply merges into it.
      r_pend_press <= (r_pend_press & ~w_clr_press) | w_press_p;
      r_pend_long  <= (r_pend_long  & ~w_clr_long)  | w_long_p;
      r_pend_rel   <= (r_pend_rel   & ~w_clr_rel)   | w_rel_p;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sel_ev;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_panel_key_encoder.sv
// Directed bench for panel_key_encoder with short debounce/long timings; events
// are checked in order against an expected queue, timings at fixed cycles.
module tb_panel_key_encoder;
  import panel_key_encoder_pkg::*;

  localparam int NUM_BTN = 5;
  localparam int EW      = 5;

  logic               clk;
  logic               rst;
  logic [NUM_BTN-1:0] btn_raw;
  logic               ev_valid;
  logic               ev_ready;
  logic [1:0]         ev_type;
  logic [2:0]         ev_id;
  logic [NUM_BTN-1:0] btn_level;
  logic               overflow;
  logic               ovf_clr;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  panel_key_encoder #(
    .NUM_BTN     (NUM_BTN),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (10),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_type  (ev_type),
    .ev_id    (ev_id),
    .btn_level(btn_level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_ev(input logic [1:0] t, input int id);
    return {t, id[2:0]};
  endfunction

  // Scoreboard the handshake that the coming posedge will perform, then
  // advance to the next negedge. An event with nothing expected compares
  // against all-ones, a code the DUT can never present.
  task automatic cycle();
    logic [EW-1:0] exp_v;
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() > 0) exp_v = exp_q.pop_front();
      else                  exp_v = '1;
      check_eq("sb_event", {27'd0, ev_type, ev_id}, {27'd0, exp_v});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  logic seen_lvl, seen_val;

  initial begin
    rst      = 1'b1;
    btn_raw  = '0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_type", ev_type, 0);
    check_eq("rst_id", ev_id, 0);
    check_eq("rst_ovf", overflow, 0);
    rst = 1'b0;
    idle(3);

    // Hold RUN 30 cycles: PRESS, LONG, RELEASE
    ev_ready = 1'b1;
    exp_q.push_back(mk_ev(EV_PRESS, BTN_RUN));
    exp_q.push_back(mk_ev(EV_LONG, BTN_RUN));
    exp_q.push_back(mk_ev(EV_RELEASE, BTN_RUN));
    btn_raw[BTN_RUN] = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      cycle();
      if (c == 5) check_eq("t1_level_c5", btn_level[BTN_RUN], 0);
      if (c == 6) begin
        check_eq("t1_level_c6", btn_level[BTN_RUN], 1);
        check_eq("t1_valid_c6", ev_valid, 0);
      end
      if (c == 7) begin
        check_eq("t1_valid_c7", ev_valid, 1);
        check_eq("t1_type_c7", ev_type, EV_PRESS);
        check_eq("t1_id_c7", ev_id, 1);
      end
      if (c == 8)  check_eq("t1_valid_c8", ev_valid, 0);
      if (c == 16) check_eq("t1_valid_c16", ev_valid, 0);
      if (c == 17) begin
        check_eq("t1_valid_c17", ev_valid, 1);
        check_eq("t1_type_c17", ev_type, EV_LONG);
      end
      if (c == 30) btn_raw[BTN_RUN] = 1'b0;
      if (c == 35) check_eq("t1_level_c35", btn_level[BTN_RUN], 1);
      if (c == 36) begin
        check_eq("t1_level_c36", btn_level[BTN_RUN], 0);
        check_eq("t1_valid_c36", ev_valid, 0);
      end
      if (c == 37) begin
        check_eq("t1_valid_c37", ev_valid, 1);
        check_eq("t1_type_c37", ev_type, EV_RELEASE);
      end
    end
    check_eq("t1_q_empty", exp_q.size(), 0);
    idle(5);

    // 3-cycle glitch on WATER: nothing
    seen_lvl = 1'b0;
    seen_val = 1'b0;
    btn_raw[BTN_WATER] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      cycle();
      if (c == 3) btn_raw[BTN_WATER] = 1'b0;
      seen_lvl |= btn_level[BTN_WATER];
      seen_val |= ev_valid;
    end
    check_eq("t2_glitch_level", seen_lvl, 0);
    check_eq("t2_glitch_event", seen_val, 0);
    idle(5);

    // RESET and OPEN rise together: PRESS 0 then PRESS 3 on adjacent cycles
    exp_q.push_back(mk_ev(EV_PRESS, BTN_RESET));
    exp_q.push_back(mk_ev(EV_PRESS, BTN_OPEN));
    exp_q.push_back(mk_ev(EV_RELEASE, BTN_RESET));
    exp_q.push_back(mk_ev(EV_RELEASE, BTN_OPEN));
    btn_raw[BTN_RESET] = 1'b1;
    btn_raw[BTN_OPEN]  = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      cycle();
      if (c == 7) begin
        check_eq("t3_valid_c7", ev_valid, 1);
        check_eq("t3_id_c7", ev_id, 0);
      end
      if (c == 8) begin
        check_eq("t3_valid_c8", ev_valid, 1);
        check_eq("t3_id_c8", ev_id, 3);
        check_eq("t3_type_c8", ev_type, EV_PRESS);
        btn_raw[BTN_RESET] = 1'b0;
        btn_raw[BTN_OPEN]  = 1'b0;
      end
      if (c == 9) check_eq("t3_valid_c9", ev_valid, 0);
    end
    check_eq("t3_q_empty", exp_q.size(), 0);
    idle(5);

    // Six events with the consumer stalled: four queued, two dropped
    ev_ready = 1'b0;
    exp_q.push_back(mk_ev(EV_PRESS, 0));
    exp_q.push_back(mk_ev(EV_PRESS, 1));
    exp_q.push_back(mk_ev(EV_PRESS, 2));
    exp_q.push_back(mk_ev(EV_RELEASE, 0));
    btn_raw[2:0] = 3'b111;
    for (int c = 1; c <= 30; c++) begin
      cycle();
      if (c == 8) btn_raw[2:0] = 3'b000;
      if (c == 9) check_eq("t4_head_c9", ev_id, 0);
      if (c == 15) begin
        check_eq("t4_ovf_c15", overflow, 0);
        check_eq("t4_valid_c15", ev_valid, 1);
        ovf_clr = 1'b1;
      end
      if (c == 16) begin
        check_eq("t4_ovf_drop_vs_clr", overflow, 1);
        ovf_clr = 1'b0;
      end
      if (c == 20) ev_ready = 1'b1;
      if (c == 25) begin
        check_eq("t4_drained", ev_valid, 0);
        check_eq("t4_ovf_sticky", overflow, 1);
      end
    end
    check_eq("t4_q_empty", exp_q.size(), 0);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    check_eq("t4_ovf_cleared", overflow, 0);
    idle(5);

    // Full queue, pop and push on the same edge: no drop
    ev_ready = 1'b0;
    for (int b = 0; b < 5; b++) exp_q.push_back(mk_ev(EV_PRESS, b));
    for (int b = 0; b < 5; b++) exp_q.push_back(mk_ev(EV_RELEASE, b));
    btn_raw[3:0] = 4'b1111;
    for (int c = 1; c <= 30; c++) begin
      cycle();
      if (c == 5) btn_raw[BTN_CLICK] = 1'b1;
      if (c == 8) btn_raw[3:0] = 4'b0000;
      if (c == 10) begin
        check_eq("t6_valid_c10", ev_valid, 1);
        check_eq("t6_head_c10", ev_id, 0);
        btn_raw[BTN_CLICK] = 1'b0;
      end
      if (c == 11) ev_ready = 1'b1;
      if (c == 12) begin
        check_eq("t6_ovf_c12", overflow, 0);
        check_eq("t6_head_c12", ev_id, 1);
      end
      if (c == 30) begin
        check_eq("t6_ovf_end", overflow, 0);
        check_eq("t6_valid_end", ev_valid, 0);
      end
    end
    check_eq("t6_q_empty", exp_q.size(), 0);
    idle(5);

    // Reset with two queued events while CLICK is held
    ev_ready = 1'b0;
    btn_raw[BTN_OPEN]  = 1'b1;
    btn_raw[BTN_CLICK] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cycle();
      if (c == 8) begin
        check_eq("t5_valid_pre", ev_valid, 1);
        check_eq("t5_head_pre", ev_id, 3);
      end
    end
    rst = 1'b1;
    btn_raw[BTN_OPEN] = 1'b0;
    #1;
    check_eq("t5_valid_in_rst", ev_valid, 0);
    check_eq("t5_level_in_rst", btn_level, 0);
    idle(3);
    ev_ready = 1'b1;
    rst = 1'b0;
    exp_q.push_back(mk_ev(EV_PRESS, BTN_CLICK));
    exp_q.push_back(mk_ev(EV_RELEASE, BTN_CLICK));
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (c == 3) check_eq("t5_valid_c3", ev_valid, 0);
      if (c == 5) check_eq("t5_level_c5", btn_level[BTN_CLICK], 0);
      if (c == 6) begin
        check_eq("t5_level_c6", btn_level[BTN_CLICK], 1);
        check_eq("t5_valid_c6", ev_valid, 0);
      end
      if (c == 7) begin
        check_eq("t5_valid_c7", ev_valid, 1);
        check_eq("t5_id_c7", ev_id, 4);
        check_eq("t5_type_c7", ev_type, EV_PRESS);
      end
      if (c == 8) btn_raw[BTN_CLICK] = 1'b0;
    end
    check_eq("t5_q_empty", exp_q.size(), 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
